syscall_print_unit: RTL and testbench
=====================================

# syscall_print_unit

Sequential service engine for the MIPS print syscalls, sitting beside the data memory on the MEM stage. On a syscall it walks a null-terminated string in data memory one word per fetch, or takes a single character from `rega`. It emits bytes over a valid/ready stream to the console/testbench sink. While it runs it holds a pipeline stall.

## Interface
Parameters:
- `ADDR_W`, 32: word-address width of the data-memory read port.
- `MAX_WORDS`, 256: runaway guard; maximum words fetched per string.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sys` in 1: syscall strobe from decode/EX, level; a start is its rising edge.
- `regv` in 32: service code (`$v0`).
- `rega` in 32: argument (`$a0`): word address for string, character for char.
- `mem_addr` out ADDR_W: read address into the data memory.
- `mem_rdata` in 32: combinational read data for `mem_addr`, same cycle.
- `busy` out 1: pipeline stall request.
- `out_valid` out 1: byte available.
- `out_byte` out 8: byte value.
- `out_ready` in 1: sink accepts byte.
- `done` out 1: one-cycle pulse at end of service.
- `trunc` out 1: valid with `done`; high when the `MAX_WORDS` guard fired.

## Operation
- States: IDLE, FETCH, EMIT, NL, FIN.
- **Start detection**
  - In IDLE, `sys & ~sys_q` with `regv==4` latches `ptr<=rega`, `wcnt<=0`, and goes to FETCH.
  - `regv==11` latches `word<=rega`, `bidx<=0`, sets a char-mode flag, and goes to EMIT.
  - Any other code is ignored: no busy, no done.
- **FETCH** (one cycle)
  - `mem_addr=ptr`.
  - Captures `word<=mem_rdata`, `bidx<=0`, `ptr<=ptr+1` modulo 2^ADDR_W, `wcnt<=wcnt+1`.
  - Goes to EMIT.
- **EMIT**
  - Current byte is `word[8*bidx+:8]`, little-endian, `[7:0]` first.
  - If the byte is 0x00: go to NL or FIN; nothing emitted.
  - Otherwise `out_valid=1`. On `out_ready` the byte is consumed. Then:
    - char mode: go to NL/FIN;
    - `bidx==3` and `wcnt==MAX_WORDS`: go to NL/FIN with trunc set;
    - `bidx==3` otherwise: go to FETCH;
    - else `bidx++`.
- **NL**: emits 0x0A under the same handshake, then goes to FIN. This state exists only when the configuration macro below is defined.
- **FIN**: `done=1` for one cycle, `trunc` per the guard; then IDLE.
- `busy` is high in every state except IDLE.
- `sys` edges arriving while not in IDLE are ignored. `sys_q` still tracks `sys`, so a held-high `sys` does not retrigger.
- **Reset** (async, any state): state IDLE; `ptr`, `word`, `bidx`, `wcnt`, `sys_q` cleared. Outputs reset to `busy=0`, `out_valid=0`, `out_byte=0`, `mem_addr=0`, `done=0`, `trunc=0`. A byte pending mid-handshake is dropped.

## Timing
- Start edge sampled at edge N. FETCH occupies cycle N+1, with `busy=1` from N+1. The first `out_valid` is at N+2.
- The byte is transferred on a rising edge where `out_valid & out_ready`.
- `out_byte` is stable while `out_valid & ~out_ready`. `out_valid` does not drop without a transfer, except on reset.
- With `out_ready` held at 1, each word takes 5 cycles: 1 FETCH plus 4 EMIT.
- Terminator detection costs no extra cycle: the zero byte's EMIT cycle moves directly to NL/FIN.
- An empty string (first byte 0) gives: FETCH, EMIT, FIN. `done` is at N+3 without the macro.
- `mem_addr` is registered from `ptr` and held constant outside FETCH.
- Pointer wrap 0xFFFFFFFF→0 is legal and not flagged.

## Configuration
- `SYSPRINT_NEWLINE_EN`
  - Defined: NL state is present; every completed service, including char and truncated strings, ends with one 0x0A byte before `done`.
  - Undefined: NL is absent; EMIT goes directly to FIN.

## Structure
- `sysprint_pkg`: state enum, `SYS_PRINT_STR=4`, `SYS_PRINT_CHAR=11`, `NEWLINE=8'h0A`.
- One sub-module, `sysprint_byte_sel`: combinational byte extraction from `word` and `bidx`, plus a zero-byte flag.
- The FSM and counters stay in the top module.

## Test plan
- String "Hi!" + 0x00, stored as word 0x00216948 at 0xFFFF0000, with `regv=4` and `rega=0xFFFF0000`, `out_ready=1`:
  - expected bytes 0x48 0x69 0x21 (+0x0A if the macro is defined), one `done`, `trunc=0`;
  - `busy` high for exactly the run.
- Two-word string 0x64636261, 0x00000065: bytes "abcde". Exactly 2 FETCH cycles; `mem_addr` steps FFFF0000→FFFF0001.
- `regv=11`, `rega=0x41`, with `out_ready` low for 3 cycles: `out_valid` and `out_byte=0x41` held for 3 cycles, transferred on cycle 4, then `done`.
- With `MAX_WORDS=2` and memory with no zero byte: 8 bytes emitted, then `done` with `trunc=1`. A `sys` edge mid-run is ignored.
- Assert `rst_n` low during EMIT with `out_valid=1`: all outputs are 0 immediately. After release, no `done` occurs and a fresh `sys` edge restarts normally.
- `regv=10`, and `sys` held high for 5 cycles: no `busy`, no output, no `done`, no retrigger.

Source files
------------

// File: rtl/sysprint_pkg.sv
// Shared types and constants for syscall_print_unit: FSM state encoding and the
// MIPS print service codes.
package sysprint_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EMIT  = 3'd2,
    ST_NL    = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
  localparam logic [7:0]  NEWLINE        = 8'h0A;

endpackage

// File: rtl/sysprint_byte_sel.sv
// Little-endian byte extraction from a fetched word, plus a flag marking the
// string terminator (zero byte).
module sysprint_byte_sel (
  input  logic [31:0] i_word,
  input  logic [1:0]  i_bidx,
  output logic [7:0]  o_byte,
  output logic        o_zero
);

  always_comb begin
    o_byte = 8'h00;
    case (i_bidx)
      2'd0: o_byte = i_word[7:0];
      2'd1: o_byte = i_word[15:8];
      2'd2: o_byte = i_word[23:16];
      2'd3: o_byte = i_word[31:24];
      default: o_byte = 8'h00;
    endcase
  end

  assign o_zero = (o_byte == 8'h00);

endmodule

// File: rtl/syscall_print_unit.sv
// Print-syscall service engine: streams a null-terminated string from data memory
// (or one character from rega) as bytes. Optional trailing newline: SYSPRINT_NEWLINE_EN.
//
// state | meaning
// IDLE  | waiting for a rising edge on sys with a print code
// FETCH | reading one word at ptr, advancing ptr and the word count
// EMIT  | presenting the current byte; zero byte ends the string
// NL    | presenting the trailing 0x0A (only with SYSPRINT_NEWLINE_EN)
// FIN   | one-cycle done pulse, trunc reports the word-limit guard
module syscall_print_unit
  import sysprint_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sys,
  input  logic [31:0]       regv,
  input  logic [31:0]       rega,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              out_valid,
  output logic [7:0]        out_byte,
  input  logic              out_ready,
  output logic              done,
  output logic              trunc
);

  localparam int WCNT_W = $clog2(MAX_WORDS + 1);

`ifdef SYSPRINT_NEWLINE_EN
  localparam state_t ST_END = ST_NL;
`else
  localparam state_t ST_END = ST_FIN;
`endif

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [31:0]         r_word;
  logic [1:0]          r_bidx;
  logic [WCNT_W-1:0]   r_wcnt;
  logic                r_sys_q;
  logic                r_char;
  logic                r_trunc_pend;
  logic                r_byte_zero;
  logic                r_busy;
  logic                r_out_valid;
  logic [7:0]          r_out_byte;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_done;
  logic                r_trunc;

  logic                w_start;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_ptr_nxt;
  logic [31:0]         w_word_nxt;
  logic [1:0]          w_bidx_nxt;
  logic [WCNT_W-1:0]   w_wcnt_nxt;
  logic                w_char_nxt;
  logic                w_trunc_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [7:0]          w_sel_byte;
  logic                w_sel_zero;

  assign w_start = sys & ~r_sys_q & (r_state == ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_word_nxt  = r_word;
    w_bidx_nxt  = r_bidx;
    w_wcnt_nxt  = r_wcnt;
    w_char_nxt  = r_char;
    w_trunc_nxt = r_trunc_pend;
    w_addr_nxt  = r_mem_addr;
    case (r_state)
      ST_IDLE: begin
        if (w_start && regv == SYS_PRINT_STR) begin
          w_state_nxt = ST_FETCH;
          w_ptr_nxt   = ADDR_W'(rega);
          w_addr_nxt  = ADDR_W'(rega);
          w_wcnt_nxt  = '0;
          w_char_nxt  = 1'b0;
          w_trunc_nxt = 1'b0;
        end else if (w_start && regv == SYS_PRINT_CHAR) begin
          w_state_nxt = ST_EMIT;
          w_word_nxt  = rega;
          w_bidx_nxt  = 2'd0;
          w_char_nxt  = 1'b1;
          w_trunc_nxt = 1'b0;
        end
      end
      ST_FETCH: begin
        w_state_nxt = ST_EMIT;
        w_word_nxt  = mem_rdata;
        w_bidx_nxt  = 2'd0;
        w_ptr_nxt   = r_ptr + ADDR_W'(1);
        w_wcnt_nxt  = r_wcnt + WCNT_W'(1);
      end
      ST_EMIT: begin
        if (r_byte_zero) begin
          w_state_nxt = ST_END;
        end else if (out_ready) begin
          if (r_char) begin
            w_state_nxt = ST_END;
          end else if (r_bidx == 2'd3) begin
            if (r_wcnt == WCNT_W'(MAX_WORDS)) begin
              w_state_nxt = ST_END;
              w_trunc_nxt = 1'b1;
            end else begin
              // ptr was already advanced by the previous FETCH
              w_state_nxt = ST_FETCH;
              w_addr_nxt  = r_ptr;
            end
          end else begin
            w_bidx_nxt = r_bidx + 2'd1;
          end
        end
      end
`ifdef SYSPRINT_NEWLINE_EN
      ST_NL: begin
        if (out_ready) w_state_nxt = ST_FIN;
      end
`endif
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Byte selection runs on next-state data so the stream outputs can be registered.
  sysprint_byte_sel u_byte_sel (
    .i_word (w_word_nxt),
    .i_bidx (w_bidx_nxt),
    .o_byte (w_sel_byte),
    .o_zero (w_sel_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_word       <= '0;
      r_bidx       <= '0;
      r_wcnt       <= '0;
      r_sys_q      <= 1'b0;
      r_char       <= 1'b0;
      r_trunc_pend <= 1'b0;
      r_byte_zero  <= 1'b0;
      r_busy       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_byte   <= 8'h00;
      r_mem_addr   <= '0;
      r_done       <= 1'b0;
      r_trunc      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_word       <= w_word_nxt;
      r_bidx       <= w_bidx_nxt;
      r_wcnt       <= w_wcnt_nxt;
      r_sys_q      <= sys;
      r_char       <= w_char_nxt;
      r_trunc_pend <= w_trunc_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_mem_addr   <= w_addr_nxt;
      r_done       <= (w_state_nxt == ST_FIN);
      r_trunc      <= (w_state_nxt == ST_FIN) && w_trunc_nxt;
      case (w_state_nxt)
        ST_EMIT: begin
          r_out_valid <= ~w_sel_zero;
          r_out_byte  <= w_sel_byte;
          r_byte_zero <= w_sel_zero;
        end
        ST_NL: begin
          r_out_valid <= 1'b1;
          r_out_byte  <= NEWLINE;
          r_byte_zero <= 1'b0;
        end
        default: begin
          r_out_valid <= 1'b0;
          r_out_byte  <= 8'h00;
          r_byte_zero <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_byte  = r_out_byte;
  assign mem_addr  = r_mem_addr;
  assign done      = r_done;
  assign trunc     = r_trunc;

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_byte)));

  a_done_busy: assert property (@(posedge clk) disable iff (!rst_n)
    done |-> busy);

endmodule

// File: tb/tb_syscall_print_unit.sv
// Self-checking bench for syscall_print_unit: directed scenarios plus randomized
// services, all checked against a string-walking reference model.
module tb_syscall_print_unit;

  localparam int MAXW = 2;
`ifdef SYSPRINT_NEWLINE_EN
  localparam int NL_C = 1;
`else
  localparam int NL_C = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sys = 1'b0;
  logic [31:0] regv = '0;
  logic [31:0] rega = '0;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        out_valid;
  logic [7:0]  out_byte;
  logic        out_ready = 1'b1;
  logic        done;
  logic        trunc;

  logic [31:0] tb_mem [64];
  assign mem_rdata = tb_mem[mem_addr[5:0]];

  always #5 clk = ~clk;

  syscall_print_unit #(.ADDR_W(32), .MAX_WORDS(MAXW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sys       (sys),
    .regv      (regv),
    .rega      (rega),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .out_valid (out_valid),
    .out_byte  (out_byte),
    .out_ready (out_ready),
    .done      (done),
    .trunc     (trunc)
  );

  int          n_assert = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  rx_q [$];
  logic [31:0] addr_log [$];
  bit          exp_trunc;
  int          exp_cycles;
  bit          svc_active = 1'b0;
  int          busy_cnt = 0;
  int          stall_cnt = 0;
  int          done_cnt = 0;
  int          done_base = 0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_byte = '0;
  bit          rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: walk memory word by word, little-endian bytes, stop on zero or word cap.
  task automatic model(input logic [31:0] code, input logic [31:0] arg);
    int f = 0;
    int b = 0;
    int z = 0;
    bit stop = 1'b0;
    logic [31:0] a;
    logic [31:0] w;
    exp_q.delete();
    exp_trunc = 1'b0;
    exp_cycles = 0;
    if (code == 32'd11) begin
      if (arg[7:0] != 8'h00) exp_q.push_back(arg[7:0]);
      exp_cycles = 1 + NL_C + 1;
    end else if (code == 32'd4) begin
      a = arg;
      for (int i = 0; i < MAXW && !stop; i++) begin
        w = tb_mem[a[5:0]];
        f++;
        a = a + 32'd1;
        for (int j = 0; j < 4 && !stop; j++) begin
          if (w[8*j +: 8] == 8'h00) begin
            z = 1;
            stop = 1'b1;
          end else begin
            exp_q.push_back(w[8*j +: 8]);
            b++;
          end
        end
      end
      exp_trunc = !stop;
      exp_cycles = f + b + z + NL_C + 1;
    end
`ifdef SYSPRINT_NEWLINE_EN
    if (code == 32'd4 || code == 32'd11) exp_q.push_back(8'h0A);
`endif
  endtask

  // Called at posedge+1; sys is raised now and lowered after 'hold' cycles.
  task automatic kick(input logic [31:0] code, input logic [31:0] arg, input int hold);
    model(code, arg);
    svc_active = (code == 32'd4 || code == 32'd11);
    busy_cnt = 0;
    stall_cnt = 0;
    rx_q.delete();
    addr_log.delete();
    done_base = done_cnt;
    regv = code;
    rega = arg;
    sys = 1'b1;
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    sys = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int i = 0;
    while (done_cnt == done_base && i < 400) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk({name, "_done_seen"}, 64'(done_cnt != done_base), 64'd1);
    if (done_cnt == done_base) begin
      svc_active = 1'b0;
      exp_q.delete();
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_byte", out_byte, prev_byte);
      end
      if (out_valid && out_ready) begin
        rx_q.push_back(out_byte);
        if (exp_q.size() > 0) chk("byte", out_byte, exp_q.pop_front());
        else chk("extra_byte_valid", out_valid, 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_byte = out_byte;
      if (out_valid && !out_ready) stall_cnt++;
      if (busy) begin
        busy_cnt++;
        if (addr_log.size() == 0 || addr_log[$] != mem_addr) addr_log.push_back(mem_addr);
      end
      if (!svc_active) begin
        chk("busy_idle", busy, 0);
        chk("valid_idle", out_valid, 0);
      end
      if (done) begin
        done_cnt++;
        chk("done_active", svc_active, 1);
        chk("bytes_left", exp_q.size(), 0);
        chk("trunc", trunc, exp_trunc);
        chk("busy_cycles", busy_cnt, exp_cycles + stall_cnt);
        svc_active = 1'b0;
      end else if (trunc) begin
        chk("trunc_without_done", trunc, 0);
      end
    end
  end

  logic [7:0] abcde [5] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
  logic [7:0] hi [3] = '{8'h48, 8'h69, 8'h21};

  initial begin
    int db;
    int k;
    logic [31:0] code;
    logic [31:0] arg;
    for (int i = 0; i < 64; i++) tb_mem[i] = 32'h0;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_byte", out_byte, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_trunc", trunc, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // "Hi!" string with model pinned by literals
    tb_mem[0] = 32'h00216948;
    model(32'd4, 32'hFFFF0000);
    chk("model_hi_len", exp_q.size(), 64'(3 + NL_C));
    chk("model_hi_cycles", exp_cycles, 64'(6 + NL_C));
    chk("model_hi_trunc", exp_trunc, 0);
    kick(32'd4, 32'hFFFF0000, 1);
    @(negedge clk);
    chk("hi_busy_n1", busy, 1);
    chk("hi_addr_n1", mem_addr, 32'hFFFF0000);
    chk("hi_valid_n1", out_valid, 0);
    @(negedge clk);
    chk("hi_valid_n2", out_valid, 1);
    chk("hi_first_byte", out_byte, 8'h48);
    wait_done("hi");
    chk("hi_rx_len", rx_q.size(), 64'(3 + NL_C));
    for (int i = 0; i < 3 && i < rx_q.size(); i++) chk("hi_rx", rx_q[i], hi[i]);

    // two-word "abcde"
    tb_mem[0] = 32'h64636261;
    tb_mem[1] = 32'h00000065;
    kick(32'd4, 32'hFFFF0000, 1);
    wait_done("abcde");
    chk("abcde_rx_len", rx_q.size(), 64'(5 + NL_C));
    for (int i = 0; i < 5 && i < rx_q.size(); i++) chk("abcde_rx", rx_q[i], abcde[i]);
    chk("abcde_fetches", addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      chk("abcde_addr0", addr_log[0], 32'hFFFF0000);
      chk("abcde_addr1", addr_log[1], 32'hFFFF0001);
    end

    // char with 3 stalled cycles
    out_ready = 1'b0;
    kick(32'd11, 32'h00000041, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("char_stall_valid", out_valid, 1);
      chk("char_stall_byte", out_byte, 8'h41);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("char_xfer_valid", out_valid, 1);
    wait_done("char");
    chk("char_rx_len", rx_q.size(), 64'(1 + NL_C));
    if (rx_q.size() > 0) chk("char_rx", rx_q[0], 8'h41);

    // truncation with a mid-run sys edge
    tb_mem[0] = 32'h11223344;
    tb_mem[1] = 32'h55667788;
    tb_mem[2] = 32'h99AABBCC;
    model(32'd4, 32'hFFFF0000);
    chk("model_trunc_len", exp_q.size(), 64'(8 + NL_C));
    chk("model_trunc_flag", exp_trunc, 1);
    chk("model_trunc_cycles", exp_cycles, 64'(11 + NL_C));
    kick(32'd4, 32'hFFFF0000, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    regv = 32'd4;
    rega = 32'hFFFF0002;
    sys = 1'b1;
    @(posedge clk);
    #1 sys = 1'b0;
    wait_done("trunc");
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("trunc_single_done", done_cnt, done_base + 1);
    if (rx_q.size() >= 8) chk("trunc_last_byte", rx_q[7], 8'h55);

    // pointer wrap
    tb_mem[63] = 32'h6F6C6C65;
    tb_mem[0]  = 32'h00000021;
    kick(32'd4, 32'hFFFFFFFF, 1);
    wait_done("wrap");
    chk("wrap_rx_len", rx_q.size(), 64'(5 + NL_C));
    if (addr_log.size() == 2) chk("wrap_addr1", addr_log[1], 32'h0);
    else chk("wrap_fetches", addr_log.size(), 2);

    // reset during EMIT
    tb_mem[0] = 32'h11223344;
    tb_mem[1] = 32'h55667788;
    kick(32'd4, 32'hFFFF0000, 1);
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("rst_mid_valid_seen", out_valid, 1);
    rst_n = 1'b0;
    svc_active = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_byte", out_byte, 0);
    chk("rst_mid_addr", mem_addr, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_trunc", trunc, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    db = done_cnt;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("rst_no_done", done_cnt, db);
    tb_mem[0] = 32'h00216948;
    kick(32'd4, 32'hFFFF0000, 1);
    wait_done("post_rst");
    chk("post_rst_rx_len", rx_q.size(), 64'(3 + NL_C));

    // unsupported code with sys held high
    db = done_cnt;
    kick(32'd10, 32'h00001234, 5);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("code10_done", done_cnt, db);
    chk("code10_busy_cycles", busy_cnt, 0);
    chk("code10_bytes", rx_q.size(), 0);

    // randomized services
    rand_ready = 1'b1;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 64; i++) begin
        logic [31:0] w;
        w = $urandom();
        for (int j = 0; j < 4; j++) if ($urandom_range(0, 5) == 0) w[8*j +: 8] = 8'h00;
        tb_mem[i] = w;
      end
      k = $urandom_range(0, 4);
      code = (k <= 2) ? 32'd4 : ((k == 3) ? 32'd11 : 32'd7);
      arg = $urandom();
      if (code == 32'd11 && $urandom_range(0, 7) == 0) arg[7:0] = 8'h00;
      k = $urandom_range(1, 8);
      kick(code, arg, k);
      if (code == 32'd7) begin
        db = done_base;
        repeat (4) begin
          @(posedge clk);
          #1;
        end
        chk("rand_ignored_done", done_cnt, db);
      end else begin
        wait_done("rand");
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
